// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and fill FSM state type for the VRAM arbiter
//
// Purpose: default geometry/arbitration constants and the fill engine state
// encoding shared by vram_arbiter and vram_fill_engine.
package vram_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vram_fill_engine.sv
// rtl/vram_fill_engine.sv - block fill engine (FSM plus address/count registers)
//
// Purpose: writes fill_value to fill_len consecutive words starting at
// fill_base, one word per cycle in which the arbiter grants it port A.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   fill_start/fill_abort start (IDLE only) / abort (abort wins over start)
//   fill_base/len/value   sampled on an accepted start
//   fill_gnt              arbiter granted port A to the fill this cycle
//   fill_busy/fill_done   in RUN / one-cycle completion pulse
//   fill_addr/fill_data   address and data to write when granted
module vram_fill_engine
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fill_start,
  input  logic                  fill_abort,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  fill_gnt,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data
);

  fill_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_value <= '0;
    end else begin
      case (r_state)
        FILL_IDLE: begin
          if (fill_start && !fill_abort) begin
            r_addr  <= fill_base;
            r_count <= fill_len;
            r_value <= fill_value;
            // A zero-length fill still reports completion, without writing.
            r_state <= (fill_len == '0) ? FILL_DONE : FILL_RUN;
          end
        end
        FILL_RUN: begin
          // The address wraps naturally at 2**ADDR_WIDTH.
          if (fill_gnt) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count - 1'b1;
          end
          // A grant in the abort cycle still writes; only completion is lost.
          if (fill_abort) begin
            r_state <= FILL_IDLE;
          end else if (fill_gnt && (r_count == (ADDR_WIDTH+1)'(1))) begin
            r_state <= FILL_DONE;
          end
        end
        FILL_DONE: r_state <= FILL_IDLE;
        default:   r_state <= FILL_IDLE;
      endcase
    end
  end

  // Gated by reset so the arbiter never sees a pending fill while in reset.
  assign fill_busy = !reset && (r_state == FILL_RUN);
  assign fill_done = !reset && (r_state == FILL_DONE);
  assign fill_addr = r_addr;
  assign fill_data = r_value;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - port A arbiter between CPU accesses and the block fill engine
//
// Purpose: shares RAM port A between a CPU (default winner) and an optional
// fill engine that gets idle cycles, plus one forced cycle after STARVE_MAX
// consecutive CPU grants while a fill is pending.
// Build option: define VRAM_ARBITER_FILL_EN to include the fill engine;
// otherwise fill inputs are ignored and every CPU request is granted.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request, held until cpu_gnt
//   cpu_gnt                    combinational grant
//   cpu_rvalid/cpu_rdata       read data, one cycle after a read grant
//   fill_start/abort/base/len/value, fill_busy/fill_done   fill control/status
//   ram_we/ram_addr_a/ram_din_a  RAM port A drive
//   ram_dout_a                 RAM port A data, one cycle after the address
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  fill_start,
  input  logic                  fill_abort,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a
);

  logic                  w_fill_busy;
  logic                  w_fill_gnt;
  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic [DATA_WIDTH-1:0] w_fill_data;

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;

  logic                  r_rvalid;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_din_hold;

`ifdef VRAM_ARBITER_FILL_EN
  // One extra bit so STARVE_MAX=0 still yields a legal width.
  localparam int STARVE_W = $clog2(STARVE_MAX + 2);

  logic [STARVE_W-1:0] r_starve;
  logic                w_starve_hit;
  logic                w_fill_done;

  assign w_starve_hit = (r_starve == STARVE_W'(STARVE_MAX));
  assign w_fill_gnt   = w_fill_busy && (!cpu_req || w_starve_hit);

  vram_fill_engine #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fill (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_abort (fill_abort),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_gnt   (w_fill_gnt),
    .fill_busy  (w_fill_busy),
    .fill_done  (w_fill_done),
    .fill_addr  (w_fill_addr),
    .fill_data  (w_fill_data)
  );

  // Counts CPU wins over a pending fill; any fill grant or idle fill resets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!w_fill_busy || w_fill_gnt) begin
      r_starve <= '0;
    end else if (cpu_gnt) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign fill_busy = w_fill_busy;
  assign fill_done = w_fill_done;
`else
  localparam int unused_starve_max = STARVE_MAX;

  logic w_unused_fill;
  assign w_unused_fill = ^{fill_start, fill_abort, fill_base, fill_len, fill_value};

  assign w_fill_busy = 1'b0;
  assign w_fill_gnt  = 1'b0;
  assign w_fill_addr = '0;
  assign w_fill_data = '0;
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
`endif

  assign cpu_gnt = !reset && cpu_req && !w_fill_gnt;

  // Port A mux; with no grant the address/data hold their last values.
  always_comb begin
    w_we   = 1'b0;
    w_addr = r_addr_hold;
    w_din  = r_din_hold;
    if (cpu_gnt) begin
      w_we   = cpu_we;
      w_addr = cpu_addr;
      w_din  = cpu_wdata;
    end else if (w_fill_gnt) begin
      w_we   = 1'b1;
      w_addr = w_fill_addr;
      w_din  = w_fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid    <= 1'b0;
      r_addr_hold <= '0;
      r_din_hold  <= '0;
    end else begin
      r_rvalid    <= cpu_gnt && !cpu_we;
      r_addr_hold <= w_addr;
      r_din_hold  <= w_din;
    end
  end

  // Outputs are forced to zero combinationally so they read as reset values
  // even in the first reset cycle, before the registers have been cleared.
  assign ram_we     = w_we;
  assign ram_addr_a = reset ? '0 : w_addr;
  assign ram_din_a  = reset ? '0 : w_din;
  assign cpu_rvalid = !reset && r_rvalid;
  assign cpu_rdata  = cpu_rvalid ? ram_dout_a : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a RAM model and reference memory
module tb_vram_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int SM = 4;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          fill_start, fill_abort;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic [DW-1:0] fill_value;
  logic          fill_busy, fill_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_din_a;
  logic [DW-1:0] ram_dout_a;

  int n_cmp;
  int n_fail;

  logic [DW-1:0] mem       [0:NW-1];
  logic [DW-1:0] model_mem [0:NW-1];
  logic          mem_loaded = 1'b0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .fill_start(fill_start), .fill_abort(fill_abort), .fill_base(fill_base),
    .fill_len(fill_len), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_we(ram_we), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a)
  );

  // Synchronous RAM port A: write on we, registered read of the presented address.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < NW; i++) mem[i] <= 8'(i) ^ 8'h33;
      ram_dout_a <= '0;
      mem_loaded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr_a] <= ram_din_a;
      ram_dout_a <= mem[ram_addr_a];
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 0; fill_abort = 0; fill_base = '0; fill_len = '0; fill_value = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 6'h15; cpu_wdata = 8'h99;
    fill_start = 1; fill_base = 6'h02; fill_len = 7'd8; fill_value = 8'h11;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin @(negedge clk); reset = 0; idle_inputs(); end
      else @(negedge clk);
      #1;
      n_cmp++; if ({cpu_gnt, cpu_rvalid, fill_busy, fill_done, ram_we} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl[%0d] got=%b exp=00000", k, {cpu_gnt, cpu_rvalid, fill_busy, fill_done, ram_we}); end
      n_cmp++; if (ram_addr_a !== '0) begin n_fail++; $display("FAIL reset_addr[%0d] got=%0h exp=0", k, ram_addr_a); end
      n_cmp++; if (ram_din_a !== '0) begin n_fail++; $display("FAIL reset_din[%0d] got=%0h exp=0", k, ram_din_a); end
      n_cmp++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata[%0d] got=%0h exp=0", k, cpu_rdata); end
    end
  endtask

  task automatic test_cpu_write_read();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_addr = 6'd5; cpu_wdata = 8'h2A; #1;
    n_cmp++; if ({cpu_gnt, ram_we} !== 2'b11) begin n_fail++; $display("FAIL wr_gnt_we got=%b exp=11", {cpu_gnt, ram_we}); end
    n_cmp++; if (ram_addr_a !== 6'd5) begin n_fail++; $display("FAIL wr_addr got=%0h exp=5", ram_addr_a); end
    n_cmp++; if (ram_din_a !== 8'h2A) begin n_fail++; $display("FAIL wr_din got=%0h exp=2a", ram_din_a); end
    model_mem[5] = 8'h2A;
    @(negedge clk); cpu_we = 0; #1;
    n_cmp++; if ({cpu_gnt, ram_we, cpu_rvalid} !== 3'b100) begin n_fail++; $display("FAIL rd_issue got=%b exp=100", {cpu_gnt, ram_we, cpu_rvalid}); end
    @(negedge clk); cpu_req = 0; #1;
    n_cmp++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=1", cpu_rvalid); end
    n_cmp++; if (cpu_rdata !== 8'h2A) begin n_fail++; $display("FAIL rd_rdata got=%0h exp=2a", cpu_rdata); end
    n_cmp++; if ({cpu_gnt, ram_we} !== 2'b00 || ram_addr_a !== 6'd5) begin n_fail++; $display("FAIL idle_hold got=%b/%0h exp=00/5", {cpu_gnt, ram_we}, ram_addr_a); end
    @(negedge clk); #1;
    n_cmp++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_drop got=%b exp=0", cpu_rvalid); end
  endtask

  task automatic test_random_cpu();
    logic          pend_rd;
    logic [AW-1:0] pend_addr;
    pend_rd = 0; pend_addr = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      #1;
      n_cmp++; if (cpu_gnt !== cpu_req) begin n_fail++; $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, cpu_gnt, cpu_req); end
      n_cmp++; if (ram_we !== (cpu_req & cpu_we)) begin n_fail++; $display("FAIL rnd_we[%0d] got=%b exp=%b", c, ram_we, cpu_req & cpu_we); end
      if (cpu_req) begin
        n_cmp++; if (ram_addr_a !== cpu_addr) begin n_fail++; $display("FAIL rnd_addr[%0d] got=%0h exp=%0h", c, ram_addr_a, cpu_addr); end
        if (cpu_we) begin
          n_cmp++; if (ram_din_a !== cpu_wdata) begin n_fail++; $display("FAIL rnd_din[%0d] got=%0h exp=%0h", c, ram_din_a, cpu_wdata); end
        end
      end
      n_cmp++; if (cpu_rvalid !== pend_rd) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got=%b exp=%b", c, cpu_rvalid, pend_rd); end
      if (pend_rd) begin
        n_cmp++; if (cpu_rdata !== model_mem[pend_addr]) begin n_fail++; $display("FAIL rnd_rdata[%0d] got=%0h exp=%0h", c, cpu_rdata, model_mem[pend_addr]); end
      end
      pend_rd = cpu_req && !cpu_we;
      pend_addr = cpu_addr;
      if (cpu_req && cpu_we) model_mem[cpu_addr] = cpu_wdata;
    end
    @(negedge clk); idle_inputs();
  endtask

`ifdef VRAM_ARBITER_FILL_EN
  task automatic test_fill_basic();
    @(negedge clk); fill_start = 1; fill_base = 6'h3C; fill_len = 7'd8; fill_value = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); fill_start = 0; #1;
      n_cmp++; if ({fill_busy, ram_we, cpu_gnt} !== 3'b110) begin n_fail++; $display("FAIL fill_ctrl[%0d] got=%b exp=110", k, {fill_busy, ram_we, cpu_gnt}); end
      n_cmp++; if (ram_addr_a !== AW'(60 + k) || ram_din_a !== 8'hFF) begin n_fail++; $display("FAIL fill_wr[%0d] got=%0h/%0h exp=%0h/ff", k, ram_addr_a, ram_din_a, AW'(60 + k)); end
      model_mem[AW'(60 + k)] = 8'hFF;
    end
    @(negedge clk); #1;
    n_cmp++; if ({fill_done, fill_busy, ram_we} !== 3'b100) begin n_fail++; $display("FAIL fill_done got=%b exp=100", {fill_done, fill_busy, ram_we}); end
    @(negedge clk); #1;
    n_cmp++; if ({fill_done, fill_busy} !== 2'b00) begin n_fail++; $display("FAIL fill_after got=%b exp=00", {fill_done, fill_busy}); end
  endtask

  // CPU writes held continuously in the upper half; the fill must take every (SM+1)th RUN cycle.
  task automatic test_starvation();
    logic [AW-1:0] q_addr;
    logic [DW-1:0] q_data;
    logic          exp_fill;
    q_addr = AW'(32 + $urandom_range(0, 31)); q_data = DW'($urandom);
    for (int k = 0; k <= 16 * (SM + 1); k++) begin
      @(negedge clk);
      fill_start = (k == 0); fill_base = '0; fill_len = 7'd16; fill_value = 8'hA5;
      cpu_req = 1; cpu_we = 1; cpu_addr = q_addr; cpu_wdata = q_data;
      #1;
      exp_fill = (k > 0) && (k % (SM + 1) == 0);
      n_cmp++; if (cpu_gnt !== !exp_fill) begin n_fail++; $display("FAIL starve_gnt[%0d] got=%b exp=%b", k, cpu_gnt, !exp_fill); end
      n_cmp++; if (fill_busy !== (k > 0)) begin n_fail++; $display("FAIL starve_busy[%0d] got=%b exp=%b", k, fill_busy, k > 0); end
      if (exp_fill) begin
        n_cmp++; if (ram_we !== 1'b1 || ram_addr_a !== AW'(k / (SM + 1) - 1) || ram_din_a !== 8'hA5) begin n_fail++; $display("FAIL starve_fill[%0d] got=%b/%0h/%0h exp=1/%0h/a5", k, ram_we, ram_addr_a, ram_din_a, AW'(k / (SM + 1) - 1)); end
        model_mem[AW'(k / (SM + 1) - 1)] = 8'hA5;
      end else begin
        n_cmp++; if (ram_we !== 1'b1 || ram_addr_a !== q_addr || ram_din_a !== q_data) begin n_fail++; $display("FAIL starve_cpu[%0d] got=%b/%0h/%0h exp=1/%0h/%0h", k, ram_we, ram_addr_a, ram_din_a, q_addr, q_data); end
        model_mem[q_addr] = q_data;
        q_addr = AW'(32 + $urandom_range(0, 31)); q_data = DW'($urandom);
      end
    end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if ({fill_done, fill_busy} !== 2'b10) begin n_fail++; $display("FAIL starve_done got=%b exp=10", {fill_done, fill_busy}); end
  endtask

  task automatic test_abort();
    @(negedge clk); fill_start = 1; fill_base = 6'd16; fill_len = 7'd10; fill_value = 8'h5A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); fill_start = 0; fill_abort = (k == 4); #1;
      n_cmp++; if ({fill_busy, ram_we} !== 2'b11 || ram_addr_a !== AW'(15 + k)) begin n_fail++; $display("FAIL abort_wr[%0d] got=%b/%0h exp=11/%0h", k, {fill_busy, ram_we}, ram_addr_a, AW'(15 + k)); end
      model_mem[AW'(15 + k)] = 8'h5A;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); fill_abort = 0; #1;
      n_cmp++; if ({fill_busy, fill_done, ram_we} !== 3'b000) begin n_fail++; $display("FAIL abort_after[%0d] got=%b exp=000", k, {fill_busy, fill_done, ram_we}); end
    end
    @(negedge clk); fill_start = 1; fill_abort = 1; fill_base = 6'd40; fill_len = 7'd4; fill_value = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); fill_start = 0; fill_abort = 0; #1;
      n_cmp++; if ({fill_busy, fill_done, ram_we} !== 3'b000) begin n_fail++; $display("FAIL abort_start[%0d] got=%b exp=000", k, {fill_busy, fill_done, ram_we}); end
    end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); fill_start = 1; fill_base = 6'd40; fill_len = 7'd20; fill_value = 8'h77;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); fill_start = 0; #1;
      n_cmp++; if (ram_we !== 1'b1 || ram_addr_a !== AW'(39 + k)) begin n_fail++; $display("FAIL rstfill_wr[%0d] got=%b/%0h exp=1/%0h", k, ram_we, ram_addr_a, AW'(39 + k)); end
      model_mem[AW'(39 + k)] = 8'h77;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 6'd3; cpu_wdata = 8'h44; #1;
      n_cmp++; if ({cpu_gnt, cpu_rvalid, fill_busy, fill_done, ram_we} !== 5'b0 || ram_addr_a !== '0 || ram_din_a !== '0 || cpu_rdata !== '0) begin n_fail++; $display("FAIL rstfill_out[%0d] got=%b/%0h/%0h/%0h exp=00000/0/0/0", k, {cpu_gnt, cpu_rvalid, fill_busy, fill_done, ram_we}, ram_addr_a, ram_din_a, cpu_rdata); end
    end
    @(negedge clk); reset = 0; idle_inputs(); fill_start = 1; fill_base = 6'd9; fill_len = '0; #1;
    n_cmp++; if ({fill_busy, fill_done, ram_we} !== 3'b000) begin n_fail++; $display("FAIL len0_start got=%b exp=000", {fill_busy, fill_done, ram_we}); end
    @(negedge clk); fill_start = 0; #1;
    n_cmp++; if ({fill_busy, fill_done, ram_we} !== 3'b010) begin n_fail++; $display("FAIL len0_done got=%b exp=010", {fill_busy, fill_done, ram_we}); end
    @(negedge clk); #1;
    n_cmp++; if ({fill_busy, fill_done, ram_we} !== 3'b000) begin n_fail++; $display("FAIL len0_after got=%b exp=000", {fill_busy, fill_done, ram_we}); end
  endtask
`else
  task automatic test_fill_ignored();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      fill_start = (k == 0); fill_base = '0; fill_len = 7'd8; fill_value = 8'hFF;
      cpu_req = 1; cpu_we = 0; cpu_addr = AW'($urandom); #1;
      n_cmp++; if ({cpu_gnt, ram_we, fill_busy, fill_done} !== 4'b1000) begin n_fail++; $display("FAIL nofill[%0d] got=%b exp=1000", k, {cpu_gnt, ram_we, fill_busy, fill_done}); end
    end
    @(negedge clk); idle_inputs();
  endtask
`endif

  task automatic test_mem_consistency();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      n_cmp++; if (mem[i] !== model_mem[i]) begin n_fail++; $display("FAIL mem[%0d] got=%0h exp=%0h", i, mem[i], model_mem[i]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1; idle_inputs();
    for (int i = 0; i < NW; i++) model_mem[i] = 8'(i) ^ 8'h33;
    test_reset();
    test_cpu_write_read();
    test_random_cpu();
`ifdef VRAM_ARBITER_FILL_EN
    test_fill_basic();
    test_starvation();
    test_abort();
    test_reset_mid_fill();
`else
    test_fill_ignored();
`endif
    test_mem_consistency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
